// File: rtl/genius_level_ctrl.sv
// Purpose: game-level sequencer; counts rounds and steps the 2-bit speed select only just after a speed-clock rise or a timeout.
// Latency: outputs registered, 1 CLK from START/ROUND_OK/ROUND_FAIL; speed-clock rise reaches LEVEL in 2-3 CLK via sync + edge detect.
// Backpressure: none; pulses are acted on in the cycle they arrive, OK pulses that land in PEND/IDLE/WIN are dropped.
module genius_level_ctrl #(
    parameter int ROUNDS_PER_LEVEL = 4,
    parameter int SW_TIMEOUT       = 255,
    parameter int CNT_W            = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_round_ok,
    input  logic             i_round_fail,
    input  logic             i_clkhz_in,
    output logic [1:0]       o_level,
    output logic             o_level_chg,
    output logic [CNT_W-1:0] o_round_cnt,
    output logic             o_active,
    output logic             o_game_win
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_PEND = 2'd2,
        S_WIN  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] RND_LAST = CNT_W'(ROUNDS_PER_LEVEL - 1);
    localparam logic [CNT_W-1:0] TMO_MAX  = CNT_W'(SW_TIMEOUT);

    state_t           r_state;
    logic [1:0]       r_level;
    logic [1:0]       r_next_level;
    logic             r_level_chg;
    logic [CNT_W-1:0] r_round_cnt;
    logic [CNT_W-1:0] r_tmo_cnt;
    logic             r_active;
    logic             r_game_win;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_sync3;

    logic             w_edge;
    logic             w_tmo_done;
    logic             w_last_round;

    // Bring the asynchronous speed clock into the CLK domain and keep one extra stage for edge detect
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= i_clkhz_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_edge       = r_sync2 & ~r_sync3;
    assign w_tmo_done   = (r_tmo_cnt == TMO_MAX);
    assign w_last_round = (r_round_cnt == RND_LAST);

    // Game sequencer; START beats FAIL beats OK, and every output is a flop set alongside the state
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_level      <= 2'b00;
            r_next_level <= 2'b00;
            r_level_chg  <= 1'b0;
            r_round_cnt  <= '0;
            r_tmo_cnt    <= '0;
            r_active     <= 1'b0;
            r_game_win   <= 1'b0;
        end else begin
            r_level_chg <= 1'b0;
            if (i_start) begin
                // Restart from any state; a pending level change is simply forgotten
                r_state     <= S_PLAY;
                r_level     <= 2'b00;
                r_level_chg <= (r_level != 2'b00);
                r_round_cnt <= '0;
                r_tmo_cnt   <= '0;
                r_active    <= 1'b1;
                r_game_win  <= 1'b0;
            end else begin
                case (r_state)
                    S_PLAY: begin
                        if (i_round_fail) begin
                            r_state     <= S_IDLE;
                            r_level     <= 2'b00;
                            r_level_chg <= (r_level != 2'b00);
                            r_round_cnt <= '0;
                            r_active    <= 1'b0;
                        end else if (i_round_ok) begin
                            if (w_last_round) begin
                                r_round_cnt <= '0;
                                if (r_level == 2'b11) begin
                                    r_state    <= S_WIN;
                                    r_active   <= 1'b0;
                                    r_game_win <= 1'b1;
                                end else begin
                                    // Hold the new level back until the speed clock is between pulses
                                    r_next_level <= r_level + 2'd1;
                                    r_tmo_cnt    <= '0;
                                    r_state      <= S_PEND;
                                end
                            end else begin
                                r_round_cnt <= r_round_cnt + 1'b1;
                            end
                        end
                    end
                    S_PEND: begin
                        if (i_round_fail) begin
                            r_state     <= S_IDLE;
                            r_level     <= 2'b00;
                            r_level_chg <= (r_level != 2'b00);
                            r_round_cnt <= '0;
                            r_tmo_cnt   <= '0;
                            r_active    <= 1'b0;
                        end else if (w_edge || w_tmo_done) begin
                            r_level     <= r_next_level;
                            r_level_chg <= 1'b1;
                            r_tmo_cnt   <= '0;
                            r_state     <= S_PLAY;
                        end else begin
                            r_tmo_cnt <= r_tmo_cnt + 1'b1;
                        end
                    end
                    S_WIN: begin
                        r_level    <= 2'b11;
                        r_game_win <= 1'b1;
                    end
                    default: begin
                        r_active   <= 1'b0;
                        r_game_win <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_level     = r_level;
    assign o_level_chg = r_level_chg;
    assign o_round_cnt = r_round_cnt;
    assign o_active    = r_active;
    assign o_game_win  = r_game_win;

endmodule

// File: tb/tb_genius_level_ctrl.sv
// Purpose: randomized and directed check of genius_level_ctrl against a cycle-level game model.
// Latency: model is stepped on each CLK rise and compared on the following fall.
// Backpressure: not applicable; the bench drives single-cycle pulses only.
module tb_genius_level_ctrl;

    localparam int RPL   = 4;
    localparam int TMO   = 255;
    localparam int CNT_W = 8;

    localparam int M_IDLE = 0;
    localparam int M_PLAY = 1;
    localparam int M_PEND = 2;
    localparam int M_WIN  = 3;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             ok;
    logic             fail;
    logic             pin;
    logic [1:0]       o_level;
    logic             o_level_chg;
    logic [CNT_W-1:0] o_round_cnt;
    logic             o_active;
    logic             o_game_win;

    int n_checks;
    int n_err;
    int cyc;
    int pin_mode;

    // Game model state
    int m_mode;
    int m_level;
    int m_next;
    int m_rounds;
    int m_waited;
    bit m_chg;
    bit ph[$];

    genius_level_ctrl #(
        .ROUNDS_PER_LEVEL(RPL),
        .SW_TIMEOUT(TMO),
        .CNT_W(CNT_W)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_round_ok  (ok),
        .i_round_fail(fail),
        .i_clkhz_in  (pin),
        .o_level     (o_level),
        .o_level_chg (o_level_chg),
        .o_round_cnt (o_round_cnt),
        .o_active    (o_active),
        .o_game_win  (o_game_win)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic m_reset();
        m_mode   = M_IDLE;
        m_level  = 0;
        m_next   = 0;
        m_rounds = 0;
        m_waited = 0;
        m_chg    = 1'b0;
        ph       = '{1'b0, 1'b0, 1'b0};
    endtask

    // One CLK rise of the game: pin history gives the edge the controller acts on this cycle
    task automatic m_step();
        bit e;
        int old;
        if (!rst_n) begin
            m_reset();
            return;
        end
        e = ph[1] && !ph[2];
        ph.push_front(pin);
        void'(ph.pop_back());
        old   = m_level;
        m_chg = 1'b0;
        if (start) begin
            m_mode   = M_PLAY;
            m_level  = 0;
            m_rounds = 0;
            m_chg    = (old != 0);
        end else if (m_mode == M_PLAY) begin
            if (fail) begin
                m_mode   = M_IDLE;
                m_level  = 0;
                m_rounds = 0;
                m_chg    = (old != 0);
            end else if (ok) begin
                m_rounds++;
                if (m_rounds == RPL) begin
                    m_rounds = 0;
                    if (m_level == 3) m_mode = M_WIN;
                    else begin
                        m_next   = m_level + 1;
                        m_waited = 0;
                        m_mode   = M_PEND;
                    end
                end
            end
        end else if (m_mode == M_PEND) begin
            if (fail) begin
                m_mode   = M_IDLE;
                m_level  = 0;
                m_rounds = 0;
                m_chg    = (old != 0);
            end else begin
                m_waited++;
                if (e || m_waited == TMO + 1) begin
                    m_level = m_next;
                    m_chg   = 1'b1;
                    m_mode  = M_PLAY;
                end
            end
        end
    endtask

    task automatic tick();
        cyc++;
        case (pin_mode)
            1: if (cyc % 10 == 0) pin = ~pin;
            2: if ($urandom_range(0, 7) == 0) pin = ~pin;
            default: ;
        endcase
        @(posedge clk);
        m_step();
        @(negedge clk);
        chk("level", 32'(o_level), 32'(m_level));
        chk("level_chg", 32'(o_level_chg), 32'(m_chg));
        chk("round_cnt", 32'(o_round_cnt), 32'(m_rounds));
        chk("active", 32'(o_active), 32'((m_mode == M_PLAY) || (m_mode == M_PEND)));
        chk("game_win", 32'(o_game_win), 32'(m_mode == M_WIN));
    endtask

    task automatic step(input bit s, input bit o, input bit f);
        start = s;
        ok    = o;
        fail  = f;
        tick();
        start = 1'b0;
        ok    = 1'b0;
        fail  = 1'b0;
    endtask

    // Finish the four rounds of a level and let the pending change settle
    task automatic clear_level();
        for (int i = 0; i < RPL; i++) step(0, 1, 0);
        repeat (30) step(0, 0, 0);
    endtask

    initial begin
        int n;
        n_checks = 0;
        n_err    = 0;
        cyc      = 0;
        pin_mode = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        ok       = 1'b0;
        fail     = 1'b0;
        pin      = 1'b0;
        m_reset();

        // Reset state
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Timeout path: speed clock stuck low
        step(1, 0, 0);
        for (int i = 0; i < RPL; i++) step(0, 1, 0);
        chk("pend_active", 32'(o_active), 32'd1);
        n = 1;
        while (n <= 400) begin
            step(0, 0, 0);
            if (o_level_chg) break;
            n++;
        end
        chk("tmo_latency", 32'(n), 32'(TMO + 1));
        chk("tmo_level", 32'(o_level), 32'd1);

        // Edge path: single rise on the speed clock while pending
        for (int i = 0; i < RPL; i++) step(0, 1, 0);
        repeat (3) step(0, 0, 0);
        pin = 1'b1;
        n = 1;
        while (n <= 20) begin
            step(0, 0, 0);
            if (o_level_chg) break;
            n++;
        end
        chk("edge_latency", 32'(n), 32'd3);
        chk("edge_level", 32'(o_level), 32'd2);
        chk("edge_rcnt", 32'(o_round_cnt), 32'd0);

        // Full game to WIN with speed clock at 1/20 CLK
        pin_mode = 1;
        step(1, 0, 0);
        for (int l = 0; l < 4; l++) clear_level();
        chk("win_flag", 32'(o_game_win), 32'd1);
        chk("win_level", 32'(o_level), 32'd3);
        repeat (3) step(0, 1, 0);
        step(0, 0, 1);
        chk("win_hold", 32'(o_level), 32'd3);
        step(1, 0, 0);
        chk("restart_level", 32'(o_level), 32'd0);
        chk("restart_active", 32'(o_active), 32'd1);
        chk("restart_win", 32'(o_game_win), 32'd0);
        chk("restart_chg", 32'(o_level_chg), 32'd1);

        // OK and FAIL together at level 10, round 2; then START with FAIL
        clear_level();
        clear_level();
        step(0, 1, 0);
        step(0, 1, 0);
        chk("pre_rcnt", 32'(o_round_cnt), 32'd2);
        chk("pre_level", 32'(o_level), 32'd2);
        step(0, 1, 1);
        chk("okfail_level", 32'(o_level), 32'd0);
        chk("okfail_chg", 32'(o_level_chg), 32'd1);
        chk("okfail_active", 32'(o_active), 32'd0);
        step(1, 0, 1);
        chk("startfail_active", 32'(o_active), 32'd1);

        // FAIL while a change to 10 is pending
        clear_level();
        pin_mode = 0;
        pin      = 1'b0;
        for (int i = 0; i < RPL; i++) step(0, 1, 0);
        repeat (5) step(0, 0, 0);
        step(0, 0, 1);
        chk("pendfail_level", 32'(o_level), 32'd0);
        chk("pendfail_chg", 32'(o_level_chg), 32'd1);
        repeat (5) step(0, 0, 0);

        // Asynchronous reset mid-PEND
        step(1, 0, 0);
        pin_mode = 1;
        clear_level();
        pin_mode = 0;
        pin      = 1'b0;
        for (int i = 0; i < RPL; i++) step(0, 1, 0);
        repeat (4) step(0, 0, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_level", 32'(o_level), 32'd0);
        chk("arst_chg", 32'(o_level_chg), 32'd0);
        chk("arst_rcnt", 32'(o_round_cnt), 32'd0);
        chk("arst_active", 32'(o_active), 32'd0);
        chk("arst_win", 32'(o_game_win), 32'd0);
        m_reset();
        @(negedge clk);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Randomized play
        pin_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 3);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
